// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store controller.
//   - ctr encodings (access size in bits [1:0], unsigned flag in bit 2)
//   - FSM state enum, datapath widths
//   - helpers: ctr legality and effective byte-lane offset
package lsu_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  localparam logic [2:0] CTR_LB  = 3'b000;
  localparam logic [2:0] CTR_LH  = 3'b001;
  localparam logic [2:0] CTR_LW  = 3'b010;
  localparam logic [2:0] CTR_LBU = 3'b100;
  localparam logic [2:0] CTR_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  function automatic logic ctr_legal(input logic [2:0] ctr);
    case (ctr)
      CTR_LB, CTR_LH, CTR_LW, CTR_LBU, CTR_LHU: ctr_legal = 1'b1;
      default:                                  ctr_legal = 1'b0;
    endcase
  endfunction

  // Byte lane actually used for an access. Halves are forced onto an even
  // lane and words onto lane 0, so an unchecked misaligned access silently
  // rounds down instead of straddling the word.
  function automatic logic [1:0] lane_off(input logic [1:0] size,
                                          input logic [1:0] off);
    case (size)
      2'b00:   lane_off = off;
      2'b01:   lane_off = {off[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store controller.
//   Store path: replicate store data across lanes and build byte strobes.
//   Load path : shift the addressed lane down and sign/zero extend it.
// Ports:
//   i_st_size  [1:0]  store access size (ctr[1:0])
//   i_st_off   [1:0]  store byte address bits [1:0]
//   i_st_wdata [31:0] store data, LSBs significant
//   o_st_wdata [31:0] lane-replicated store data
//   o_st_wstrb [3:0]  byte enables
//   i_ld_ctr   [2:0]  load ctr encoding
//   i_ld_off   [1:0]  load byte address bits [1:0]
//   i_ld_rdata [31:0] aligned memory word
//   o_ld_data  [31:0] extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        i_st_size,
  input  logic [1:0]        i_st_off,
  input  logic [XLEN-1:0]   i_st_wdata,
  output logic [XLEN-1:0]   o_st_wdata,
  output logic [STRB_W-1:0] o_st_wstrb,
  input  logic [2:0]        i_ld_ctr,
  input  logic [1:0]        i_ld_off,
  input  logic [XLEN-1:0]   i_ld_rdata,
  output logic [XLEN-1:0]   o_ld_data
);

  logic [1:0]      w_st_off;
  logic [1:0]      w_ld_off;
  logic [XLEN-1:0] w_lane;

  always_comb begin
    w_st_off = lane_off(i_st_size, i_st_off);
    case (i_st_size)
      2'b00: begin
        o_st_wdata = {4{i_st_wdata[7:0]}};
        o_st_wstrb = 4'b0001 << w_st_off;
      end
      2'b01: begin
        o_st_wdata = {2{i_st_wdata[15:0]}};
        o_st_wstrb = 4'b0011 << w_st_off;
      end
      default: begin
        o_st_wdata = i_st_wdata;
        o_st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    w_ld_off = lane_off(i_ld_ctr[1:0], i_ld_off);
    w_lane   = i_ld_rdata >> {w_ld_off, 3'b000};
    case (i_ld_ctr)
      CTR_LB:  o_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
      CTR_LH:  o_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
      CTR_LBU: o_ld_data = {24'h0, w_lane[7:0]};
      CTR_LHU: o_ld_data = {16'h0, w_lane[15:0]};
      default: o_ld_data = w_lane;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store controller between execute and data memory.
// Handshakes (both request and response sides): a transfer happens on a rising
// edge where valid && ready are both high; the sender holds valid and payload
// stable until that edge, and ready may be low for any number of cycles.
// The memory side is request/grant: mem_req and mem_* are held until mem_gnt,
// then exactly one mem_rvalid pulse returns the data or write ack.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to turn misaligned halves and
// words into an immediate error response; otherwise they round down.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready operation handshake (ready only in IDLE)
//   req_we, req_ctr     store flag, size/extension encoding
//   req_addr, req_wdata byte address, store data
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata, rsp_err  extended load data (0 for stores/errors), error flag
//   mem_req, mem_gnt    memory request / grant
//   mem_we, mem_addr    write flag, word-aligned address
//   mem_wstrb, mem_wdata byte enables (0 for reads), replicated store data
//   mem_rvalid, mem_rdata memory response pulse and aligned word
//   dbg_state           current FSM state
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_ctr,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output lsu_state_e        dbg_state
);

  // Counter only needs to reach TIMEOUT-1: the timeout fires on the edge that
  // would have taken it to TIMEOUT.
  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        r_state;
  logic              r_we;
  logic [2:0]        r_ctr;
  logic [1:0]        r_off;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [XLEN-1:0]   r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [XLEN-1:0]   r_mem_addr;
  logic [STRB_W-1:0] r_mem_wstrb;
  logic [XLEN-1:0]   r_mem_wdata;

  logic              w_legal;
  logic              w_misalign;
  logic              w_timeout;
  logic [XLEN-1:0]   w_st_wdata;
  logic [STRB_W-1:0] w_st_wstrb;
  logic [XLEN-1:0]   w_ld_data;

  assign w_legal   = ctr_legal(req_ctr);
  assign w_timeout = (r_cnt == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_ctr[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_ctr[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Store lanes are built from the live request so they can be registered at
  // accept; load extraction uses the captured ctr/offset and the memory word.
  lsu_align u_align (
    .i_st_size  (req_ctr[1:0]),
    .i_st_off   (req_addr[1:0]),
    .i_st_wdata (req_wdata),
    .o_st_wdata (w_st_wdata),
    .o_st_wstrb (w_st_wstrb),
    .i_ld_ctr   (r_ctr),
    .i_ld_off   (r_off),
    .i_ld_rdata (mem_rdata),
    .o_ld_data  (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_ctr       <= 3'b000;
      r_off       <= 2'b00;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wstrb <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_we        <= req_we;
            r_ctr       <= req_ctr;
            r_off       <= req_addr[1:0];
            r_req_ready <= 1'b0;
            if (!w_legal || w_misalign) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state     <= ST_REQ;
              r_cnt       <= '0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= req_we;
              r_mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
              r_mem_wstrb <= req_we ? w_st_wstrb : '0;
              r_mem_wdata <= req_we ? w_st_wdata : '0;
            end
          end
        end

        ST_REQ: begin
          // A grant on the final allowed cycle loses to the timeout: the
          // request is withdrawn rather than chasing a late response.
          if (w_timeout || mem_gnt) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
          end
          if (w_timeout) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (mem_gnt) begin
              r_state <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          // Data arriving on the last allowed cycle still counts as success.
          if (mem_rvalid) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_we ? '0 : w_ld_data;
          end else if (w_timeout) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_req_ready <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_wdata = r_mem_wdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl.
// A spec-level model (byte counts, lane offsets, arithmetic extension) fills
// expected queues for memory commands and responses; a negedge process checks
// the DUT against them every cycle, and directed vectors pin literal values.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int TO = 8;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_ctr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  lsu_state_e  dbg_state;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_ctr    (req_ctr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [32:0] rsp_q[$];   // {err, rdata}
  logic [68:0] mem_q[$];   // {we, addr, wstrb, wdata}

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic int nbytes(input logic [2:0] c);
    if (c[1:0] == 2'b00) return 1;
    if (c[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit legal(input logic [2:0] c);
    return (c == 3'b000) || (c == 3'b001) || (c == 3'b010) ||
           (c == 3'b100) || (c == 3'b101);
  endfunction

  function automatic bit misal(input logic [2:0] c, input logic [31:0] a);
    int lo;
    lo = int'(a[1:0]);
    return TRAP && ((lo % nbytes(c)) != 0);
  endfunction

  function automatic int eff_off(input logic [2:0] c, input logic [31:0] a);
    int lo;
    lo = int'(a[1:0]);
    return lo - (lo % nbytes(c));
  endfunction

  function automatic logic [3:0] st_strb(input logic [2:0] c, input logic [31:0] a);
    int s;
    s = ((1 << nbytes(c)) - 1) << eff_off(c, a);
    return s[3:0];
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] c, input logic [31:0] wd);
    logic [31:0] d;
    int nb;
    nb = nbytes(c);
    for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % nb) +: 8];
    return d;
  endfunction

  function automatic logic [31:0] ld_data(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] mw);
    logic [63:0] v;
    int nb;
    nb = nbytes(c);
    v  = {32'h0, mw} >> (8 * eff_off(c, a));
    v  = v & ((64'h1 << (8 * nb)) - 64'h1);
    if (!c[2] && nb < 4 && v[8*nb-1]) v = v - (64'h1 << (8 * nb));
    return v[31:0];
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        if (mem_q.size() == 0) chk("mem_req_unexpected", 69'(mem_req), 69'd0);
        else begin
          chk("mem_cmd", {mem_we, mem_addr, mem_wstrb, (mem_we ? mem_wdata : 32'h0)}, mem_q[0]);
          if (mem_gnt) void'(mem_q.pop_front());
        end
        chk("rsp_during_req", 69'(rsp_valid), 69'd0);
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 69'(rsp_valid), 69'd0);
        else begin
          chk("rsp", {rsp_err, rsp_rdata}, rsp_q[0]);
          if (rsp_ready) void'(rsp_q.pop_front());
        end
      end
      if (req_ready) chk("idle_quiet", {mem_req, rsp_valid}, 69'd0);
    end
  end

  // ---------------- driver ----------------
  // mode 0: normal, 1: granted but no rvalid, 2: never granted
  task automatic do_op(input string name, input logic we, input logic [2:0] ctr,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mword,
                       input int gnt_dly, input int rv_dly, input int rdy_dly, input int mode,
                       input bit lit_on, input logic [31:0] lit_rdata,
                       input logic [3:0] lit_strb, input logic [31:0] lit_wdata);
    int lat_exp, lat, cyc, rq_cnt, w_cnt;
    bit granted, seen_req, trap;
    lat = 0; cyc = 1; rq_cnt = 0; w_cnt = 0; granted = 0; seen_req = 0;
    trap = !legal(ctr) || misal(ctr, addr);
    if (trap) begin
      rsp_q.push_back({1'b1, 32'h0});
      lat_exp = 1;
    end else begin
      mem_q.push_back({we, addr & 32'hFFFF_FFFC, (we ? st_strb(ctr, addr) : 4'h0),
                       (we ? st_data(ctr, wd) : 32'h0)});
      if (mode == 0) begin
        rsp_q.push_back({1'b0, (we ? 32'h0 : ld_data(ctr, addr, mword))});
        lat_exp = 3 + gnt_dly + rv_dly;
      end else begin
        rsp_q.push_back({1'b1, 32'h0});
        lat_exp = TO + 1;
      end
    end
    chk({name, "_ready"}, 69'(req_ready), 69'd1);
    req_valid = 1'b1; req_we = we; req_ctr = ctr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    // scramble request inputs after accept: the DUT must work from its capture
    req_valid = 1'b0; req_we = 1'($urandom_range(0, 1)); req_ctr = 3'($urandom_range(0, 7));
    req_addr = $urandom; req_wdata = $urandom;
    while (cyc < 100) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (rsp_valid) begin
        lat = cyc;
        break;
      end
      if (mem_req && lit_on && we && !seen_req) begin
        seen_req = 1;
        chk({name, "_strb"}, 69'(mem_wstrb), 69'(lit_strb));
        chk({name, "_wdata"}, 69'(mem_wdata), 69'(lit_wdata));
      end
      if (granted && mode == 0) begin
        if (w_cnt == rv_dly) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mword;
        end
        w_cnt++;
      end else if (mem_req && mode != 2 && !granted) begin
        if (rq_cnt == gnt_dly) mem_gnt = 1'b1;
        rq_cnt++;
      end
      @(posedge clk); #1;
      if (mem_gnt) granted = 1;
      cyc++;
    end
    chk({name, "_latency"}, 69'(lat), 69'(lat_exp));
    if (lat != 0) begin
      for (int k = 0; k < rdy_dly; k++) begin
        @(posedge clk); #1;
      end
      chk({name, "_rsp_held"}, 69'(rsp_valid), 69'd1);
      if (lit_on) chk({name, "_rdata"}, 69'(rsp_rdata), 69'(lit_rdata));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({name, "_back_to_idle"}, {req_ready, rsp_valid}, 69'b10);
    end
    if (mode == 2) mem_q.delete();
    chk({name, "_drained"}, 69'(mem_q.size() + rsp_q.size()), 69'd0);
    mem_q.delete();
    rsp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_ctr = 3'b000; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 69'(req_ready), 69'd1);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 69'd0);
    chk("reset_mem", {mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata}, 69'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    //     name    we  ctr      addr          wd            mword         gd rd rdy md lit rdata         strb     wdata
    do_op("sb",    1, CTR_LB,  32'h1003, 32'h0000_00AB, 32'h0,         0, 0, 0, 0, 1, 32'h0,         4'b1000, 32'hABAB_ABAB);
    do_op("lb",    0, CTR_LB,  32'h2001, 32'h0,         32'h0000_8000, 0, 0, 0, 0, 1, 32'hFFFF_FF80, 4'h0,    32'h0);
    do_op("lbu",   0, CTR_LBU, 32'h2001, 32'h0,         32'h0000_8000, 0, 0, 0, 0, 1, 32'h0000_0080, 4'h0,    32'h0);
    do_op("lh",    0, CTR_LH,  32'h2002, 32'h0,         32'h8001_1234, 0, 0, 0, 0, 1, 32'hFFFF_8001, 4'h0,    32'h0);
    do_op("lhu",   0, CTR_LHU, 32'h2002, 32'h0,         32'h8001_1234, 0, 0, 0, 0, 1, 32'h0000_8001, 4'h0,    32'h0);
    do_op("lw",    0, CTR_LW,  32'h2000, 32'h0,         32'h8001_1234, 0, 0, 0, 0, 1, 32'h8001_1234, 4'h0,    32'h0);
    do_op("sh_slow", 1, CTR_LH, 32'h3002, 32'h1234_BEEF, 32'h0,        5, 0, 3, 0, 1, 32'h0,         4'b1100, 32'hBEEF_BEEF);
    do_op("sw",    1, CTR_LW,  32'h4000, 32'hDEAD_BEEF, 32'h0,         0, 2, 1, 0, 1, 32'h0,         4'b1111, 32'hDEAD_BEEF);
    do_op("lb_hi", 0, CTR_LB,  32'h0013, 32'h0,         32'h7F00_0000, 1, 1, 0, 0, 1, 32'h0000_007F, 4'h0,    32'h0);
    do_op("lhu_hi", 0, CTR_LHU, 32'h0002, 32'h0,        32'hFFFE_0001, 2, 3, 2, 0, 1, 32'h0000_FFFE, 4'h0,    32'h0);
    do_op("to_wait", 0, CTR_LW, 32'h5000, 32'h0,        32'h1111_1111, 0, 0, 0, 1, 1, 32'h0,         4'h0,    32'h0);
    do_op("to_req",  1, CTR_LW, 32'h5004, 32'h1234_5678, 32'h0,        0, 0, 1, 2, 1, 32'h0,         4'b1111, 32'h1234_5678);
    do_op("ctr011", 0, 3'b011, 32'h6000, 32'h0,         32'h0,         0, 0, 0, 0, 1, 32'h0,         4'h0,    32'h0);
    do_op("ctr110", 1, 3'b110, 32'h6000, 32'h55,        32'h0,         0, 0, 2, 0, 1, 32'h0,         4'h0,    32'h0);
    do_op("ctr111", 0, 3'b111, 32'h6001, 32'h0,         32'h0,         0, 0, 0, 0, 1, 32'h0,         4'h0,    32'h0);
    // misalignment: trapped or rounded down depending on the build
    do_op("lw_mis", 0, CTR_LW, 32'h1002, 32'h0,         32'h1122_3344, 0, 0, 0, 0, 0, 32'h0,         4'h0,    32'h0);
    do_op("lh_mis", 0, CTR_LH, 32'h2003, 32'h0,         32'h8001_1234, 1, 0, 0, 0, 0, 32'h0,         4'h0,    32'h0);
    do_op("sh_mis", 1, CTR_LH, 32'h3001, 32'h0000_5566, 32'h0,         0, 1, 0, 0, 0, 32'h0,         4'h0,    32'h0);

    // reset while waiting for memory, then a stray rvalid
    mem_q.push_back({1'b0, 32'h7000, 4'h0, 32'h0});
    req_valid = 1'b1; req_we = 1'b0; req_ctr = CTR_LW; req_addr = 32'h7000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("rst_pre_state", 69'(dbg_state), 69'(ST_WAIT));
    rst = 1'b1;
    mem_q.delete();
    rsp_q.delete();
    #1;
    chk("rst_async_ready", {req_ready, mem_req, rsp_valid}, 69'b100);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_no_rsp", {req_ready, rsp_valid}, 69'b10);
      @(posedge clk); #1;
    end

    do_op("lw_after_rst", 0, CTR_LW, 32'h8000, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 0, 1, 32'h0BAD_F00D, 4'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
